// File: rtl/regfile_nrmw.sv
// Multi-ported register file: NWR write ports, NRD combinational read ports.
// Same-address writes resolve so that the highest-indexed port wins.
// Optional write-to-read forwarding and a hardwired zero register.
// clr flash-clears every register, and rst_n (synchronous, active-low)
// overrides clr and all writes.
module regfile_nrmw #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [NWR-1:0]         we,
  input  logic [NWR*AW-1:0]      waddr,
  input  logic [NWR*WIDTH-1:0]   wdata,
  input  logic [NRD*AW-1:0]      raddr,
  output logic [NRD*WIDTH-1:0]   rdata
);

  // Storage: one flip-flop word per register
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Unpacked views of the flat write and read buses
  logic [AW-1:0]    w_waddr [NWR];
  logic [WIDTH-1:0] w_wdata [NWR];
  logic [AW-1:0]    w_raddr [NRD];

  // Per-register write decode results
  logic             w_wr_hit [DEPTH];
  logic [WIDTH-1:0] w_wr_val [DEPTH];

  genvar gi;

  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr_unpack
      assign w_waddr[gi] = waddr[gi*AW +: AW];
      assign w_wdata[gi] = wdata[gi*WIDTH +: WIDTH];
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd_unpack
      assign w_raddr[gi] = raddr[gi*AW +: AW];
    end
  endgenerate

  // One-hot write decode per register; ascending port scan lets the
  // highest-indexed matching port overwrite lower ones.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_wr_hit[k] = 1'b0;
      w_wr_val[k] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (w_waddr[i] == AW'(k))) begin
          w_wr_hit[k] = 1'b1;
          w_wr_val[k] = w_wdata[i];
        end
      end
      // The zero register never accepts a write
      if ((ZERO_REG != 0) && (k == 0)) begin
        w_wr_hit[k] = 1'b0;
      end
    end
  end

  // Register update: reset beats clear, clear beats writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_wr_hit[k]) begin
          r_mem[k] <= w_wr_val[k];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [WIDTH-1:0] w_stored;
      logic [WIDTH-1:0] w_fwd;
      logic             w_fwd_hit;
      logic             w_in_range;
      logic [WIDTH-1:0] w_rd;

      assign w_in_range = (int'(w_raddr[gi]) < DEPTH);

      // Stored value via one-hot compare and OR; an address past DEPTH
      // matches no register and therefore reads 0.
      always_comb begin
        w_stored = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if (w_raddr[gi] == AW'(k)) begin
            w_stored = w_stored | r_mem[k];
          end
        end
      end

      // Forwarding from this cycle's writes; suppressed while clearing so
      // the pre-clear contents stay visible. Deliberately still active
      // during reset: rdata is purely combinational.
      always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd     = '0;
        if ((BYPASS != 0) && !clr && w_in_range) begin
          for (int i = 0; i < NWR; i++) begin
            if (we[i] && (w_waddr[i] == w_raddr[gi])) begin
              w_fwd_hit = 1'b1;
              w_fwd     = w_wdata[i];
            end
          end
        end
      end

      // Final read mux, with the zero register forced to 0 even on forwarding
      always_comb begin
        w_rd = w_fwd_hit ? w_fwd : w_stored;
        if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
          w_rd = '0;
        end
      end

      assign rdata[gi*WIDTH +: WIDTH] = w_rd;
    end
  endgenerate

endmodule
